ddram_responder: RTL
====================

# ddram_responder

Synthesizable responder for the MiSTer DDRAM Avalon-MM-style port, the memory-side end of the link that core-side DDRAM clients drive. It accepts single-beat and burst reads and writes (BURSTCNT, BE, BUSY, DOUT_READY) and serves them from an on-chip 64-bit backing store. It replaces the HPS DDR3 in simulation and standalone FPGA soak tests of cores, and it can inject BUSY stalls to exercise client flow control.

## Interface
Parameters:
- AW, 12: word-address bits of the backing store (2^AW × 64-bit words).
- BASE_HI, 4'b0011: required value of DDRAM_ADDR[28:25]; this is the 0x30000000 byte window.
- RD_LATENCY, 4: cycles from read acceptance to the first DOUT_READY beat. Legal range is 2..15.
- BUSY_EVERY, 0: inject a one-cycle BUSY every N cycles while in IDLE or WBURST. A value of 0 disables injection.

Ports (clock and reset first):
- DDRAM_CLK  in  1  sole clock
- reset  in  1  asynchronous, active-high
- DDRAM_BUSY  out  1  responder cannot accept a command or beat this cycle
- DDRAM_BURSTCNT  in  8  beat count, sampled on the command cycle only
- DDRAM_ADDR  in  29  64-bit word address, sampled on the command cycle only
- DDRAM_RD  in  1  read command
- DDRAM_WE  in  1  write command or beat
- DDRAM_DIN  in  64  write data
- DDRAM_BE  in  8  byte enables (bit n enables byte n)
- DDRAM_DOUT  out  64  read data
- DDRAM_DOUT_READY  out  1  DOUT is valid this cycle
- err  out  1  sticky protocol-error flag

## Operation
- A command or beat is accepted on a rising edge where (RD|WE) && !BUSY.
- BURSTCNT = 0 is treated as 1.
- RD and WE both high on the same cycle: the write wins and err is set.
- In window: ADDR[28:25] == BASE_HI. The store index is ADDR[AW-1:0]. The burst address increments per beat and wraps modulo 2^AW.
- Out of window: write beats are dropped, read beats return 64'h0, and err is not set.
- State machine (states IDLE, WBURST, RWAIT, RDATA):
  - IDLE, write accepted with BURSTCNT ≤ 1: the beat is written and the state stays IDLE.
  - IDLE, write accepted with BURSTCNT > 1: the first beat is written, beats_left = BURSTCNT-1, and the state moves to WBURST.
  - WBURST: each accepted WE beat writes the next address and decrements beats_left. The state returns to IDLE when beats_left reaches 0. RD asserted in WBURST is ignored and sets err.
  - IDLE, read accepted: latch the address and count, load the latency counter, and move to RWAIT.
  - RWAIT: count down, issuing the store read one cycle before the first beat, then move to RDATA.
  - RDATA: emit one beat per cycle, consecutively with no gaps, then return to IDLE.
- Write data written: DIN bytes where BE=1; other bytes are unchanged. BE is ignored for reads.
- err clears only on reset.

## Timing
- Reset values:
  - BUSY=1; it falls on the first edge after reset deasserts.
  - DOUT=0, DOUT_READY=0, err=0.
  - State is IDLE and all counters are 0.
  - Store contents are not reset.
- Read accepted at edge T:
  - BUSY is high from T+1 through the cycle of the last beat.
  - Beat k (0-based) has DOUT_READY high in cycle T+RD_LATENCY+k.
  - BUSY is low again the cycle after the last beat, so a new command can be accepted at that edge.
- A write beat accepted at edge T is visible to a read accepted at T+1 or later.
- Single-beat writes sustain one per cycle with BUSY low.
- Stall injection: BUSY_EVERY never asserts BUSY during RWAIT or RDATA, because BUSY is already high there. An injected stall in WBURST holds beats_left unchanged.
- DOUT holds its last value when DOUT_READY=0.
- Reset asserted mid-burst: immediate abort, no further beats, and no further writes.

## Structure
- Package ddram_resp_pkg holds:
  - the state enum (IDLE, WBURST, RWAIT, RDATA);
  - the window constant's default;
  - the typedef for a 64-bit word with an 8-bit BE.
- Sub-module ddram_resp_mem is a single-port 2^AW × 64 RAM with byte-enable write and 1-cycle registered read, inferable as M10K.
- The top level holds the FSM, the address, beat and latency counters, the stall-injection counter, and err.

## Test plan
- Single write then read: write DIN=64'h0123_4567_89AB_CDEF with BE=8'hFF at ADDR={4'b0011,25'h10}, then read BURSTCNT=1 → one beat equal to 64'h0123_4567_89AB_CDEF at T+4, with BUSY high T+1..T+4.
- Partial write:
  - Preload word 0x20 with all ones.
  - Write BE=8'h0C, DIN=64'h0 → readback is 64'hFFFF_FFFF_0000_FFFF.
- Burst read:
  - Preload words 0x30 and 0x31 with 64'hA and 64'hB.
  - Read BURSTCNT=2 → DOUT_READY on two consecutive cycles with 64'hA then 64'hB.
  - A read issued the cycle after the last beat is accepted.
- Burst write with wrap: write BURSTCNT=3 starting at index 2^AW-1 → words 2^AW-1, 0 and 1 are written, and the state returns to IDLE after the third beat.
- Stalls and errors:
  - With BUSY_EVERY=3, hold WE through stalls → every beat is written exactly once.
  - An out-of-window read (ADDR[28:25]=0) returns 0 and err stays 0.
  - RD during WBURST sets err=1.
- Reset mid-read: assert reset in RWAIT of a BURSTCNT=4 read → no DOUT_READY afterwards, BUSY=1 during reset and 0 one edge after release, and err=0.

Source files
------------

// File: rtl/ddram_resp_pkg.sv
// ddram_resp_pkg: types shared by the DDRAM responder and its backing store.
// Holds the FSM state enum, the default address window and the write-word bundle.
package ddram_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WBURST,
        ST_RWAIT,
        ST_RDATA
    } state_e;

    // Default DDRAM_ADDR[28:25] value: the 0x30000000 byte window
    localparam logic [3:0] BASE_HI_DEF = 4'b0011;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  be;
    } wword_t;

endpackage

// File: rtl/ddram_resp_mem.sv
// ddram_resp_mem: single-port 2^AW x 64 RAM, byte-enable write, registered read.
// Ports: clk, we/re strobes, addr, wr (data + byte enables), rdata (1-cycle latency).
module ddram_resp_mem
    import ddram_resp_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  wword_t        wr,
    output logic [63:0]   rdata
);

    logic [63:0] mem_q [2**AW];
    logic [63:0] rdata_q;

    // No reset on the array or read register so the block maps onto M10K
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wr.be[i]) begin
                    mem_q[addr][8*i +: 8] <= wr.data[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ddram_responder.sv
// ddram_responder: memory-side end of the MiSTer DDRAM port, backed by on-chip RAM.
// Ports: DDRAM_CLK, reset, DDRAM_BUSY/BURSTCNT/ADDR/RD/WE/DIN/BE/DOUT/DOUT_READY, err.
module ddram_responder
    import ddram_resp_pkg::*;
#(
    parameter int         AW         = 12,
    parameter logic [3:0] BASE_HI    = BASE_HI_DEF,
    parameter int         RD_LATENCY = 4,
    parameter int         BUSY_EVERY = 0
) (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    output logic        DDRAM_BUSY,
    input  logic [7:0]  DDRAM_BURSTCNT,
    input  logic [28:0] DDRAM_ADDR,
    input  logic        DDRAM_RD,
    input  logic        DDRAM_WE,
    input  logic [63:0] DDRAM_DIN,
    input  logic [7:0]  DDRAM_BE,
    output logic [63:0] DDRAM_DOUT,
    output logic        DDRAM_DOUT_READY,
    output logic        err
);

    localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    LAT_LOAD   = 4'(RD_LATENCY - 1);
    localparam logic [7:0]    STALL_LAST = (BUSY_EVERY == 0) ? 8'd0 : 8'(BUSY_EVERY - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    beats_q, beats_d;
    logic [3:0]    lat_q, lat_d;
    logic [7:0]    stall_q, stall_d;
    logic          win_q, win_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;
    logic          zero_q, zero_d;

    logic          acc;
    logic          in_win;
    logic [7:0]    cnt;
    logic [AW-1:0] cmd_idx;
    logic          inject;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    wword_t        mem_wr;
    logic [63:0]   mem_rdata;
    logic          unused_addr;

    assign acc         = (DDRAM_RD | DDRAM_WE) & ~busy_q;
    assign in_win      = (DDRAM_ADDR[28:25] == BASE_HI);
    assign cnt         = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
    assign cmd_idx     = DDRAM_ADDR[AW-1:0];
    assign mem_wr      = '{data: DDRAM_DIN, be: DDRAM_BE};
    assign unused_addr = ^DDRAM_ADDR[24:AW];

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beats_d  = beats_q;
        lat_d    = lat_q;
        stall_d  = stall_q;
        win_d    = win_q;
        err_d    = err_q;
        zero_d   = zero_q;
        rdy_d    = 1'b0;
        inject   = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    win_d = in_win;
                    if (DDRAM_WE) begin
                        // Write wins a simultaneous RD, which is flagged
                        err_d    = err_q | DDRAM_RD;
                        mem_we   = in_win;
                        mem_addr = cmd_idx;
                        addr_d   = cmd_idx + ADDR_ONE;
                        if (cnt > 8'd1) begin
                            beats_d = cnt - 8'd1;
                            state_d = ST_WBURST;
                        end
                    end else begin
                        addr_d  = cmd_idx;
                        beats_d = cnt - 8'd1;
                        lat_d   = LAT_LOAD;
                        state_d = ST_RWAIT;
                    end
                end
            end
            ST_WBURST: begin
                if (DDRAM_RD) begin
                    err_d = 1'b1;
                end
                if (DDRAM_WE && !busy_q) begin
                    mem_we  = win_q;
                    addr_d  = addr_q + ADDR_ONE;
                    beats_d = beats_q - 8'd1;
                    if (beats_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RWAIT: begin
                lat_d = lat_q - 4'd1;
                // RAM read one cycle ahead of the first beat
                if (lat_q == 4'd1) begin
                    mem_re  = 1'b1;
                    addr_d  = addr_q + ADDR_ONE;
                    zero_d  = ~win_q;
                    rdy_d   = 1'b1;
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (beats_q != 8'd0) begin
                    mem_re  = 1'b1;
                    addr_d  = addr_q + ADDR_ONE;
                    beats_d = beats_q - 8'd1;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Stall counter only runs where BUSY would otherwise be low
        if ((BUSY_EVERY != 0) && (state_q == ST_IDLE || state_q == ST_WBURST)) begin
            inject  = (stall_q == STALL_LAST);
            stall_d = inject ? 8'd0 : stall_q + 8'd1;
        end

        busy_d = (state_d == ST_RWAIT) || (state_d == ST_RDATA) || inject;
    end

    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            lat_q   <= '0;
            stall_q <= '0;
            win_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            lat_q   <= lat_d;
            stall_q <= stall_d;
            win_q   <= win_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            zero_q  <= zero_d;
        end
    end

    ddram_resp_mem #(
        .AW (AW)
    ) u_mem (
        .clk   (DDRAM_CLK),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wr    (mem_wr),
        .rdata (mem_rdata)
    );

    // zero_q masks the RAM output for out-of-window beats and after reset
    assign DDRAM_DOUT       = zero_q ? 64'd0 : mem_rdata;
    assign DDRAM_DOUT_READY = rdy_q;
    assign DDRAM_BUSY       = busy_q;
    assign err              = err_q;

endmodule
